shift_unit: RTL and testbench

Two-stage pipelined shift unit for the mARC integer datapath, between the operand/ALU-input registers and the result writeback mux. It wraps the combinational `right_shifter` and adds logical-left and arithmetic-right shifts (bit reversal and sign fill), N/Z flag generation, and a valid/ready handshake with full backpressure. Shift results are ready two cycles after acceptance, and the unit sustains one operation per cycle.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/right_shifter.sv | 22 ++
 rtl/shift_unit.sv | 139 +++++++++++++
 tb/tb_shift_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: op encodings and the bit-reversal helper.
package shift_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  // Widest datapath the bit-reversal helper supports. Callers zero-extend
  // their operand to this width and truncate the result back down.
  localparam int BITREV_MAX = 64;

  // Reverse the low 'width' bits of v. Bits at and above 'width' come back 0.
  function automatic logic [BITREV_MAX-1:0] bitreverse(
    input logic [BITREV_MAX-1:0] v,
    input int                    width
  );
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < width) begin
        r[i] = v[width-1-i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/right_shifter.sv
// Combinational logarithmic right shifter (logical, zero fill).
module right_shifter #(
  parameter int WIDTH = 32,
  parameter int LEVEL = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [LEVEL-1:0] amt,
  output logic [WIDTH-1:0] result
);

  // stage[l] holds the operand after shift-amount bits 0..l-1 were applied.
  logic [WIDTH-1:0] stage [LEVEL+1];

  assign stage[0] = data;

  for (genvar l = 0; l < LEVEL; l++) begin : g_level
    assign stage[l+1] = amt[l] ? (stage[l] >> (1 << l)) : stage[l];
  end

  assign result = stage[LEVEL];

endmodule

// File: rtl/shift_unit.sv
// Two-stage pipelined shift unit (SRL / SRA / SLL) with N/Z/err flags and a
// valid/ready handshake. SLL and SRA reuse the right shifter: SLL reverses the
// operand before and the result after; SRA ORs in a sign-fill mask. WIDTH must
// be a power of two between 4 and 64.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int LEVEL = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [LEVEL-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Stage 1 state
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [LEVEL-1:0] s1_amt;
  logic [WIDTH-1:0] s1_a;
  logic             s1_sign;

  // Stage 2 valid; the S2 data registers are the outputs themselves
  logic             s2_valid;

  // Handshake and datapath nets
  logic             s2_load;
  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic             sign_in;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] res;
  logic             res_err;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Prepare the stage-1 operand: reverse for SLL, capture sign only for SRA.
  always_comb begin
    a_eff   = a;
    sign_in = 1'b0;
    if (op == OP_SLL) begin
      a_eff = WIDTH'(bitreverse(BITREV_MAX'(a), WIDTH));
    end else begin
      a_eff = a;
    end
    if (op == OP_SRA) begin
      sign_in = a[WIDTH-1];
    end else begin
      sign_in = 1'b0;
    end
  end

  right_shifter #(.WIDTH(WIDTH), .LEVEL(LEVEL)) u_data_shift (
    .data   (s1_a),
    .amt    (s1_amt),
    .result (shifted)
  );

  // Shifting all-ones leaves zeros exactly where the sign fill must go.
  right_shifter #(.WIDTH(WIDTH), .LEVEL(LEVEL)) u_mask_shift (
    .data   (ALL_ONES),
    .amt    (s1_amt),
    .result (mask)
  );

  // Form the final result and error flag from the stage-1 contents.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (s1_op)
      OP_SRL: res = shifted;
      OP_SRA: res = shifted | (s1_sign ? ~mask : '0);
      OP_SLL: res = WIDTH'(bitreverse(BITREV_MAX'(shifted), WIDTH));
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  // Stage 1: load on acceptance, empty when its entry moves on, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_amt   <= '0;
      s1_a     <= '0;
      s1_sign  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op;
      s1_amt   <= amt;
      s1_a     <= a_eff;
      s1_sign  <= sign_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: load from S1 when free or being drained, clear when taken, else hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      n        <= 1'b0;
      z        <= 1'b0;
      err      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      y        <= res;
      n        <= res[WIDTH-1];
      z        <= (res == '0);
      err      <= res_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed and randomized self-checking bench for shift_unit (WIDTH = 32).
module tb_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        n;
  logic        z;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] y;
    logic        err;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [1:0]  op;
  } exp_t;

  exp_t sb[$];

  shift_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .n         (n),
    .z         (z),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_y(input logic [1:0] o, input logic [31:0] av, input logic [4:0] am);
    case (o)
      2'b00:   return av >> am;
      2'b01:   return 32'($signed(av) >>> am);
      2'b10:   return av << am;
      default: return 32'h0;
    endcase
  endfunction

  // Single op with out_ready high; called just after a falling edge.
  task automatic run_single(input string tag, input logic [1:0] o, input logic [31:0] av,
                            input logic [4:0] am, input logic [31:0] ey, input logic ee);
    op = o; a = av; amt = am; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({tag, "/lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "/valid"}, 64'(out_valid), 64'd1);
    check({tag, "/y"},     64'(y),   64'(ey));
    check({tag, "/n"},     64'(n),   64'(ey[31]));
    check({tag, "/z"},     64'(z),   64'(ey == 32'h0));
    check({tag, "/err"},   64'(err), 64'(ee));
    @(posedge clk); @(negedge clk);
    check({tag, "/taken"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int cycles;
    logic [31:0] bp_a [5];
    logic [31:0] bp_exp [$];
    exp_t e;

    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = 32'h0; amt = 5'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/y",         64'(y),         64'd0);
    check("rst/n",         64'(n),         64'd0);
    check("rst/z",         64'(z),         64'd0);
    check("rst/err",       64'(err),       64'd0);
    check("rst/in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single operations
    run_single("srl4",    2'b00, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0);
    run_single("sra31",   2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    run_single("sll31",   2'b10, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_single("sll_out", 2'b10, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b0);
    run_single("illegal", 2'b11, 32'h0000_1234, 5'd3,  32'h0000_0000, 1'b1);
    run_single("srl0",    2'b00, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0);
    run_single("sra_pos", 2'b01, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0);
    run_single("sra_neg", 2'b01, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0);
    run_single("sll4",    2'b10, 32'h0000_1234, 5'd4,  32'h0001_2340, 1'b0);
    run_single("sra0",    2'b01, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0);

    // Backpressure: offer 5 ops with out_ready low, only 2 fit
    bp_a[0] = 32'h1000_0000; bp_a[1] = 32'h2000_0000; bp_a[2] = 32'h3000_0000;
    bp_a[3] = 32'h4000_0000; bp_a[4] = 32'h5000_0000;
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      op = 2'b00; a = bp_a[accepted]; amt = 5'd4; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        bp_exp.push_back(bp_a[accepted] >> 4);
        accepted++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp/accepted", 64'(accepted), 64'd2);
    check("bp/in_ready", 64'(in_ready), 64'd0);
    check("bp/stall_y",  64'(y),        64'h0100_0000);
    @(posedge clk); @(negedge clk);
    check("bp/stall_hold", 64'(y),      64'h0100_0000);
    out_ready = 1'b1;
    #1;
    check("bp/out0_valid", 64'(out_valid), 64'd1);
    check("bp/out0_y",     64'(y),         64'(bp_exp[0]));
    @(posedge clk); @(negedge clk);
    check("bp/out1_valid", 64'(out_valid), 64'd1);
    check("bp/out1_y",     64'(y),         64'(bp_exp[1]));
    @(posedge clk); @(negedge clk);
    check("bp/drained",    64'(out_valid), 64'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0; op = 2'b01; a = 32'hC000_0000; amt = 5'd2; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'h0000_00FF;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("mrst/full_valid", 64'(out_valid), 64'd1);
    check("mrst/full_ready", 64'(in_ready),  64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst/valid_drop", 64'(out_valid), 64'd0);
    check("mrst/in_ready",   64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("mrst/no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized stream against the reference model
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a         = $urandom;
      amt       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd/spurious", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rnd/y",   64'(y),   64'(e.y));
          check("rnd/n",   64'(n),   64'(e.y[31]));
          check("rnd/z",   64'(z),   64'(e.y == 32'h0));
          check("rnd/err", 64'(err), 64'(e.err));
          if (e.amt == 5'd0 && e.op != 2'b11) check("rnd/amt0", 64'(y), 64'(e.a));
        end
      end
      if (in_valid && in_ready) begin
        e.y = ref_y(op, a, amt); e.err = (op == 2'b11); e.a = a; e.amt = amt; e.op = op;
        sb.push_back(e);
        accepted++;
      end
    end
    check("rnd/accepted", 64'(accepted), 64'd1000);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while (sb.size() != 0 && cycles < 100) begin
      #1;
      if (out_valid) begin
        e = sb.pop_front();
        check("drain/y",   64'(y),   64'(e.y));
        check("drain/err", 64'(err), 64'(e.err));
      end
      @(negedge clk);
      cycles++;
    end
    check("drain/left", 64'(sb.size()), 64'd0);
    #1;
    check("drain/idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
